// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS front-end PC sequencer.
package mips_pkg;
  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_PC      = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEF_EXC_VECTOR    = 32'h8000_0180;
  localparam int              DEF_FETCH_TIMEOUT = 16;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } pcseq_state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus: request/address out, ack/read data back.
interface pc_sequencer_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_sequencer_npc_calc.sv
// Next-PC selection: sequential, branch and jump targets with
// jump > branch > sequential priority. All sums wrap mod 2^32.
module npc_calc
  import mips_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_offset,
  input  logic            jump,
  input  logic [25:0]     jump_index,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] npc
);
  logic signed [PC_W-1:0] br_disp;
  logic        [PC_W-1:0] br_target;
  logic        [PC_W-1:0] jmp_target;

  // Targets are relative to pc+4 (delay-slot-free view of the MIPS rules).
  always_comb begin
    pc_plus4   = pc + PC_W'(4);
    br_disp    = $signed(branch_offset) <<< 2;
    br_target  = pc_plus4 + $unsigned(br_disp);
    jmp_target = {pc_plus4[31:28], jump_index, 2'b00};
    npc        = pc_plus4;
    if (jump) begin
      npc = jmp_target;
    end else if (branch_taken) begin
      npc = br_target;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch sequencer for the MIPS front end.
// Optional feature macro: PC_EXCEPTION_EN (adds exc_req/epc and the
// exception redirect to EXC_VECTOR, which overrides stall and redirects).
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int              FETCH_TIMEOUT = DEF_FETCH_TIMEOUT,
  parameter logic [PC_W-1:0] RESET_PC      = DEF_RESET_PC
`ifdef PC_EXCEPTION_EN
  ,
  parameter logic [PC_W-1:0] EXC_VECTOR    = DEF_EXC_VECTOR
`endif
) (
  input  logic             clk,
  input  logic             reset,
  pc_sequencer_if.master   imem,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  pc_plus4,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic             fetch_err
`ifdef PC_EXCEPTION_EN
  ,
  input  logic             exc_req,
  output logic [PC_W-1:0]  epc
`endif
);
  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  pcseq_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0] npc;
`ifdef PC_EXCEPTION_EN
  logic [PC_W-1:0] epc_q, epc_d;
`endif

  npc_calc u_npc (
    .pc            (pc_q),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .pc_plus4      (pc_plus4),
    .npc           (npc)
  );

  // Next-state logic; imem_req/instr_valid are set on state entry so they are registered.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef PC_EXCEPTION_EN
    epc_d   = epc_q;
`endif
    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ISSUE: begin
`ifdef PC_EXCEPTION_EN
        if (exc_req) begin
          epc_d   = pc_q;
          pc_d    = EXC_VECTOR;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else
`endif
        if (!stall) begin
          pc_d    = npc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = S_RESET;
    endcase
  end

  // State registers; reset aborts any in-flight fetch immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef PC_EXCEPTION_EN
      epc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef PC_EXCEPTION_EN
      epc_q   <= epc_d;
`endif
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign instr          = instr_q;
  assign pc_out         = pc_q;
  assign fetch_err      = err_q;
`ifdef PC_EXCEPTION_EN
  assign epc            = epc_q;
`endif
endmodule
